// File: rtl/bgd_mul_fix_pipe.sv
// Pipelined signed fixed-point multiplier with round-half-up right shift.
// Latency is NUM_STAGE ce-qualified cycles: input register, NUM_STAGE-2
// product/shift stages, output register.
// Optional macro BGD_MUL_FIX_PIPE_SAT_EN: clamp the result to the dout range,
// drive sat_flag and count clamped results in sat_cnt. Without it the result
// wraps and sat_flag/sat_cnt are constant 0.
module bgd_mul_fix_pipe #(
  parameter int unsigned DIN0_WIDTH = 13,
  parameter int unsigned DIN1_WIDTH = 13,
  parameter int unsigned DOUT_WIDTH = 13,
  parameter int unsigned NUM_STAGE  = 4,
  parameter int unsigned FRAC_SHIFT = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  din_valid,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  clr_cnt,
  output logic                  dout_valid,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  sat_flag,
  output logic [15:0]           sat_cnt
);

  localparam int unsigned PW  = DIN0_WIDTH + DIN1_WIDTH;
  localparam int unsigned RW  = PW + 1;
  localparam int unsigned MID = NUM_STAGE - 2;
  localparam int unsigned RSH = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;
  localparam logic [RW-1:0] RND = (FRAC_SHIFT > 0) ? (RW'(1) << RSH) : '0;
  localparam logic signed [63:0] MAXV = $signed((64'(1) << (DOUT_WIDTH - 1)) - 64'(1));
  localparam logic signed [63:0] MINV = -MAXV - 64'sd1;

  logic [DIN0_WIDTH-1:0] a_q, a_d;
  logic [DIN1_WIDTH-1:0] b_q, b_d;
  logic                  in_v_q, in_v_d;

  // Input register: capture operands and valid on ce edges.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    in_v_d = in_v_q;
    if (ce) begin
      a_d    = din0;
      b_d    = din1;
      in_v_d = din_valid;
    end
  end

  // Input register state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q    <= '0;
      b_q    <= '0;
      in_v_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      in_v_q <= in_v_d;
    end
  end

  logic signed [PW-1:0] prod_c;
  logic signed [RW-1:0] sum_c;
  logic signed [RW-1:0] rnd_c;

  // Full-precision product, then round-half-up shift with one guard bit.
  always_comb begin
    prod_c = $signed(a_q) * $signed(b_q);
    sum_c  = RW'(prod_c) + $signed(RND);
    rnd_c  = sum_c >>> FRAC_SHIFT;
  end

  logic signed [RW-1:0] tail_r;
  logic                 tail_v;

  if (MID > 0) begin : g_mid
    logic [MID-1:0][RW-1:0] r_q, r_d;
    logic [MID-1:0]         v_q, v_d;

    // Delay line carrying the rounded result towards the output register.
    always_comb begin
      r_d = r_q;
      v_d = v_q;
      if (ce) begin
        r_d[0] = rnd_c;
        v_d[0] = in_v_q;
        for (int unsigned i = 1; i < MID; i++) begin
          r_d[i] = r_q[i-1];
          v_d[i] = v_q[i-1];
        end
      end
    end

    // Delay line state.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_q <= '0;
        v_q <= '0;
      end else begin
        r_q <= r_d;
        v_q <= v_d;
      end
    end

    assign tail_r = $signed(r_q[MID-1]);
    assign tail_v = v_q[MID-1];
  end else begin : g_no_mid
    assign tail_r = rnd_c;
    assign tail_v = in_v_q;
  end

  logic signed [63:0]    t64_c;
  logic [DOUT_WIDTH-1:0] res_c;
  logic                  sat_c;

  // Fit the rounded result into the output width (clamp or wrap).
  always_comb begin
    t64_c = 64'(tail_r);
    res_c = DOUT_WIDTH'(t64_c);
    sat_c = 1'b0;
`ifdef BGD_MUL_FIX_PIPE_SAT_EN
    if (t64_c > MAXV) begin
      res_c = DOUT_WIDTH'(MAXV);
      sat_c = 1'b1;
    end else if (t64_c < MINV) begin
      res_c = DOUT_WIDTH'(MINV);
      sat_c = 1'b1;
    end
`endif
  end

  logic                  dv_q, dv_d;
  logic [DOUT_WIDTH-1:0] dout_q, dout_d;
  logic                  sat_q, sat_d;

  // Output register: data and flag forced to 0 when no result is present.
  always_comb begin
    dv_d   = dv_q;
    dout_d = dout_q;
    sat_d  = sat_q;
    if (ce) begin
      dv_d   = tail_v;
      dout_d = tail_v ? res_c : '0;
      sat_d  = tail_v & sat_c;
    end
  end

  // Output register state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dv_q   <= 1'b0;
      dout_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      dv_q   <= dv_d;
      dout_q <= dout_d;
      sat_q  <= sat_d;
    end
  end

  assign dout_valid = dv_q;
  assign dout       = dout_q;
  assign sat_flag   = sat_q;

`ifdef BGD_MUL_FIX_PIPE_SAT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        inc_c;

  // Saturating count of clamped results; clear wins but keeps a coincident increment.
  always_comb begin
    cnt_d = cnt_q;
    inc_c = ce & tail_v & sat_c;
    if (clr_cnt) begin
      cnt_d = {15'd0, inc_c};
    end else if (inc_c && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat_cnt = cnt_q;
`else
  logic unused_c;
  assign unused_c = ^{clr_cnt, t64_c};
  assign sat_cnt  = '0;
`endif

endmodule

// File: doc/bgd_mul_fix_pipe.md
BGD_MUL_FIX_PIPE -- requirements
Module: bgd_mul_fix_pipe

Interface
- REQ-001 Parameter DIN0_WIDTH, default 13: signed width of din0, range 2..24.
- REQ-002 Parameter DIN1_WIDTH, default 13: signed width of din1, range 2..24.
- REQ-003 Parameter DOUT_WIDTH, default 13: signed width of dout, range 2..48.
- REQ-004 Parameter NUM_STAGE, default 4: input-to-output latency in ce-qualified cycles, range 2..8.
- REQ-005 Parameter FRAC_SHIFT, default 0: arithmetic right shift applied to the product, range 0..DIN0_WIDTH+DIN1_WIDTH-1.
- REQ-006 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
- REQ-007 Port reset, input, 1 bit: asynchronous, active-low reset.
- REQ-008 Port ce, input, 1 bit: pipeline advance enable.
- REQ-009 Port din_valid, input, 1 bit: din0/din1 carry an operand pair.
- REQ-010 Port din0, input, DIN0_WIDTH bits: signed multiplicand.
- REQ-011 Port din1, input, DIN1_WIDTH bits: signed multiplier.
- REQ-012 Port clr_cnt, input, 1 bit: synchronous clear of sat_cnt; not gated by ce.
- REQ-013 Port dout_valid, output, 1 bit: dout carries a result.
- REQ-014 Port dout, output, DOUT_WIDTH bits: signed result.
- REQ-015 Port sat_flag, output, 1 bit: the current result was clamped.
- REQ-016 Port sat_cnt, output, 16 bits: count of clamped results.

Function
- REQ-017 The pipeline SHALL advance only on clock edges where ce=1; with ce=0, all data, valid and flag registers hold.
- REQ-018 The block SHALL sample din0, din1 and din_valid on ce=1 edges; its pipeline is NUM_STAGE register stages: input register, NUM_STAGE-2 product/shift stages, output register.
- REQ-019 A pair sampled at ce edge k SHALL appear on dout with dout_valid=1 after ce edge k+NUM_STAGE-1, i.e. NUM_STAGE ce-qualified cycles.
- REQ-020 Results SHALL leave in input order, one per ce cycle; there are no bubbles except those from din_valid=0.
- REQ-021 Arithmetic: P = din0*din1, full precision in DIN0_WIDTH+DIN1_WIDTH bits.
- REQ-022 Rounding: R = (P + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT, computed with one guard bit; the rounding term is 0 when FRAC_SHIFT=0. This is round-half-up (toward +inf).
- REQ-023 dout and sat_flag SHALL be 0 whenever dout_valid=0.
- REQ-024 sat_cnt SHALL increment by 1 on each edge where the output register loads a result with sat_flag=1.
- REQ-025 sat_cnt SHALL saturate at 0xFFFF.
- REQ-026 clr_cnt=1 SHALL reset sat_cnt to 0; if it coincides with an increment, sat_cnt becomes 1.

Reset
- REQ-027 reset=0 SHALL immediately force all pipeline registers, dout_valid, dout, sat_flag and sat_cnt to 0, independent of clk and ce.
- REQ-028 Operands in flight at reset SHALL be discarded; no dout_valid pulse for them after reset release.
- REQ-029 The first pair after reset release SHALL obey REQ-019 unchanged.

Configuration
- REQ-030 Macro BGD_MUL_FIX_PIPE_SAT_EN defined: R SHALL be clamped to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1], with sat_flag=1 when clamped.
- REQ-031 Macro undefined: dout SHALL be the low DOUT_WIDTH bits of R (two's-complement wrap); sat_flag and sat_cnt are constant 0 and the counter logic is omitted.

Verification
- REQ-032 Defaults, ce=1, one pulse of din0=25, din1=-3 -> dout=-75 (0x1FB5) with a single-cycle dout_valid exactly 4 cycles later.
- REQ-033 Defaults, din0=4095, din1=4095 -> with SAT_EN: dout=4095, sat_flag=1, sat_cnt 0->1; without SAT_EN: dout=1, sat_flag=0.
- REQ-034 FRAC_SHIFT=8, pairs (3,128), (-3,128), (384,-128) -> dout 2, -1, -192 in order.
- REQ-035 Three back-to-back valid pairs, ce=0 for 2 cycles mid-flight -> outputs held during the stall, order preserved, latency 6 cycles.
- REQ-036 Reset asserted with 3 pairs in flight -> dout_valid, dout and sat_cnt are 0 immediately; no outputs after release until new input + 4 cycles.
- REQ-037 SAT_EN, 65536 clamped results -> sat_cnt holds 0xFFFF; clr_cnt together with a clamped result -> sat_cnt=1.
